// File: rtl/instr_queue.sv
// ---------------------------------------------------------------------------
// instr_queue
//
// Instruction queue between fetch and decode in the RV64 front end.
// Fetch groups of up to FETCH_NUM instructions are written into a circular
// buffer. The DECODE_NUM oldest entries are presented to decode every cycle.
// Decode consumes in order from slot 0 and may take only part of what is shown.
//
// Ports
//   clk          clock; all state changes on the rising edge
//   rst          asynchronous, active-high reset (pointers and count only)
//   flush        discards every entry; takes priority over push and pop
//   fetch_valid  a fetch group is present this cycle
//   fetch_cnt    number of valid instructions in the group, packed from 0
//   fetch_pc     PC of fetch_instr[0]; entry k gets fetch_pc + 4*k
//   fetch_instr  fetched instructions
//   fetch_ready  the queue can accept a full group (from registered count)
//   instr        oldest instructions, slot 0 oldest; NOP in invalid slots
//   instr_pc     PC of each slot; 0 in invalid slots
//   instr_valid  per-slot valid, contiguous from bit 0
//   dec_accept   instructions consumed by decode this cycle
// ---------------------------------------------------------------------------
module instr_queue #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DECODE_NUM = 4,
    parameter int unsigned FETCH_NUM  = 4,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic                                  fetch_valid,
    input  logic [$clog2(FETCH_NUM):0]            fetch_cnt,
    input  logic [DATA_WIDTH-1:0]                 fetch_pc,
    input  logic [FETCH_NUM-1:0][31:0]            fetch_instr,
    output logic                                  fetch_ready,
    output logic [DECODE_NUM-1:0][31:0]           instr,
    output logic [DECODE_NUM-1:0][DATA_WIDTH-1:0] instr_pc,
    output logic [DECODE_NUM-1:0]                 instr_valid,
    input  logic [$clog2(DECODE_NUM):0]           dec_accept
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned FCNT_W = $clog2(FETCH_NUM) + 1;

    localparam logic [31:0]      NOP       = 32'h0000_0013;
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - FETCH_NUM);

    // Pointer / occupancy state
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Entry storage; contents are don't-care until written, so no reset
    logic [31:0]           mem_instr_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_pc_q    [DEPTH];

    logic [CNT_W-1:0] push_n;
    logic [CNT_W-1:0] pop_n;

    logic [FETCH_NUM-1:0]                 wr_en;
    logic [FETCH_NUM-1:0][PTR_W-1:0]      wr_idx;
    logic [FETCH_NUM-1:0][DATA_WIDTH-1:0] wr_pc;

    logic [DECODE_NUM-1:0][PTR_W-1:0] rd_idx;

    // Only the registered count decides readiness, keeping fetch_ready free
    // of any path from fetch_* or dec_accept.
    always_comb begin
        fetch_ready = (count_q <= READY_MAX);
    end

    // Number of entries written this edge. An out-of-range fetch_cnt is
    // clamped to FETCH_NUM so the tail can never skip over live entries.
    always_comb begin
        push_n = '0;
        if (fetch_valid && fetch_ready && !flush) begin
            if (fetch_cnt > FCNT_W'(FETCH_NUM)) begin
                push_n = CNT_W'(FETCH_NUM);
            end else begin
                push_n = CNT_W'(fetch_cnt);
            end
        end
    end

    // Number of entries retired this edge: min(dec_accept, count, DECODE_NUM).
    // Clamping against count keeps an over-accept from underflowing.
    always_comb begin
        pop_n = CNT_W'(dec_accept);
        if (pop_n > count_q) begin
            pop_n = count_q;
        end
        if (pop_n > CNT_W'(DECODE_NUM)) begin
            pop_n = CNT_W'(DECODE_NUM);
        end
        if (flush) begin
            pop_n = '0;
        end
    end

    // Per-lane write address, enable and PC (PC arithmetic wraps silently)
    always_comb begin
        for (int unsigned k = 0; k < FETCH_NUM; k++) begin
            wr_en[k]  = (CNT_W'(k) < push_n);
            wr_idx[k] = tail_q + PTR_W'(k);
            wr_pc[k]  = fetch_pc + (DATA_WIDTH'(k) << 2);
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < FETCH_NUM; k++) begin
            if (wr_en[k]) begin
                mem_instr_q[wr_idx[k]] <= fetch_instr[k];
                mem_pc_q[wr_idx[k]]    <= wr_pc[k];
            end
        end
    end

    // Next-state for pointers and count; flush overrides push and pop
    always_comb begin
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(pop_n);
            tail_d  = tail_q + PTR_W'(push_n);
            count_d = count_q + push_n - pop_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Decode view: slot j shows entry head+j; purely a function of registers
    always_comb begin
        for (int unsigned j = 0; j < DECODE_NUM; j++) begin
            rd_idx[j]      = head_q + PTR_W'(j);
            instr_valid[j] = (CNT_W'(j) < count_q);
            if (CNT_W'(j) < count_q) begin
                instr[j]    = mem_instr_q[rd_idx[j]];
                instr_pc[j] = mem_pc_q[rd_idx[j]];
            end else begin
                instr[j]    = NOP;
                instr_pc[j] = '0;
            end
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
module tb_instr_queue;

    localparam int DW    = 64;
    localparam int DN    = 4;
    localparam int FN    = 4;
    localparam int DEPTH = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic                   clk;
    logic                   rst;
    logic                   flush;
    logic                   fetch_valid;
    logic [2:0]             fetch_cnt;
    logic [DW-1:0]          fetch_pc;
    logic [FN-1:0][31:0]    fetch_instr;
    logic                   fetch_ready;
    logic [DN-1:0][31:0]    instr;
    logic [DN-1:0][DW-1:0]  instr_pc;
    logic [DN-1:0]          instr_valid;
    logic [2:0]             dec_accept;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0]   ins;
        logic [DW-1:0] pc;
    } ent_t;

    // Scoreboard: entries expected to be in the queue, oldest first
    ent_t sb_q[$];

    instr_queue #(
        .DATA_WIDTH (DW),
        .DECODE_NUM (DN),
        .FETCH_NUM  (FN),
        .DEPTH      (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .fetch_valid (fetch_valid),
        .fetch_cnt   (fetch_cnt),
        .fetch_pc    (fetch_pc),
        .fetch_instr (fetch_instr),
        .fetch_ready (fetch_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .dec_accept  (dec_accept)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got=running exp=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- model accessors ----------------
    function automatic logic [DN-1:0] exp_valid();
        logic [DN-1:0] v;
        for (int j = 0; j < DN; j++) v[j] = (j < sb_q.size());
        return v;
    endfunction

    function automatic logic [31:0] exp_ins(int j);
        if (j < sb_q.size()) return sb_q[j].ins;
        return NOP;
    endfunction

    function automatic logic [DW-1:0] exp_pc(int j);
        if (j < sb_q.size()) return sb_q[j].pc;
        return '0;
    endfunction

    function automatic logic exp_ready();
        return (sb_q.size() <= DEPTH - FN);
    endfunction

    task automatic idle();
        fetch_valid = 1'b0;
        dec_accept  = '0;
        flush       = 1'b0;
    endtask

    task automatic load_group(input logic [DW-1:0] pc, input int cnt);
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        fetch_cnt   = 3'(cnt);
        for (int k = 0; k < FN; k++) fetch_instr[k] = $urandom;
    endtask

    // One clock edge; the scoreboard records what the inputs imply at that edge
    task automatic tick();
        int            sz;
        bit            do_push;
        int            pop_n;
        int            cnt;
        logic [DW-1:0] pc0;
        logic [FN-1:0][31:0] ins_c;
        bit            fl;
        ent_t          e;
        sz      = sb_q.size();
        fl      = flush;
        do_push = fetch_valid && (sz <= DEPTH - FN) && !flush;
        pop_n   = int'(dec_accept);
        if (pop_n > sz) pop_n = sz;
        if (pop_n > DN) pop_n = DN;
        cnt     = int'(fetch_cnt);
        pc0     = fetch_pc;
        ins_c   = fetch_instr;
        @(posedge clk);
        #1;
        if (fl) begin
            sb_q.delete();
        end else begin
            repeat (pop_n) void'(sb_q.pop_front());
            if (do_push) begin
                for (int k = 0; k < cnt; k++) begin
                    e.ins = ins_c[k];
                    e.pc  = pc0 + 64'(4 * k);
                    sb_q.push_back(e);
                end
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle();
        fetch_cnt   = '0;
        fetch_pc    = '0;
        fetch_instr = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (instr_valid !== 4'b0000) begin
            n_fail++; $display("FAIL reset_valid got=%b exp=0000", instr_valid);
        end
        n_checks++;
        if (fetch_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready got=%b exp=1", fetch_ready);
        end
        for (int j = 0; j < DN; j++) begin
            n_checks++;
            if (instr[j] !== NOP || instr_pc[j] !== '0) begin
                n_fail++;
                $display("FAIL reset_slot%0d got=%h/%h exp=%h/0", j, instr[j], instr_pc[j], NOP);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
    endtask

    task automatic test_push_basic();
        fetch_valid    = 1'b1;
        fetch_cnt      = 3'd4;
        fetch_pc       = 64'h8000_0000;
        fetch_instr[0] = 32'h00A0_0093;
        fetch_instr[1] = 32'h0010_8113;
        fetch_instr[2] = 32'h0020_81B3;
        fetch_instr[3] = 32'h0031_0233;
        tick();
        idle();
        n_checks++;
        if (instr_valid !== exp_valid()) begin
            n_fail++; $display("FAIL push_valid got=%b exp=%b", instr_valid, exp_valid());
        end
        n_checks++;
        if (fetch_ready !== exp_ready()) begin
            n_fail++; $display("FAIL push_ready got=%b exp=%b", fetch_ready, exp_ready());
        end
        for (int j = 0; j < DN; j++) begin
            n_checks++;
            if (instr[j] !== exp_ins(j) || instr_pc[j] !== exp_pc(j)) begin
                n_fail++;
                $display("FAIL push_slot%0d got=%h/%h exp=%h/%h", j, instr[j], instr_pc[j], exp_ins(j), exp_pc(j));
            end
        end
    endtask

    task automatic test_partial();
        dec_accept = 3'd3;
        tick();
        idle();
        n_checks++;
        if (instr_valid !== exp_valid()) begin
            n_fail++; $display("FAIL partial_valid got=%b exp=%b", instr_valid, exp_valid());
        end
        for (int j = 0; j < DN; j++) begin
            n_checks++;
            if (instr[j] !== exp_ins(j) || instr_pc[j] !== exp_pc(j)) begin
                n_fail++;
                $display("FAIL partial_slot%0d got=%h/%h exp=%h/%h", j, instr[j], instr_pc[j], exp_ins(j), exp_pc(j));
            end
        end
        dec_accept = 3'd4;
        tick();
        idle();
    endtask

    task automatic test_fill();
        int guard;
        for (int g = 0; g < 4; g++) begin
            n_checks++;
            if (fetch_ready !== exp_ready()) begin
                n_fail++; $display("FAIL fill_ready_g%0d got=%b exp=%b", g, fetch_ready, exp_ready());
            end
            load_group(64'h0000_1000 + 64'(16 * g), 4);
            tick();
        end
        idle();
        n_checks++;
        if (fetch_ready !== exp_ready()) begin
            n_fail++; $display("FAIL fill_full_ready got=%b exp=%b", fetch_ready, exp_ready());
        end
        // fetch_valid held high while not ready: nothing may be written
        for (int c = 0; c < 3; c++) begin
            load_group(64'h0000_5000 + 64'(16 * c), 4);
            tick();
            n_checks++;
            if (instr_valid !== exp_valid() || fetch_ready !== exp_ready()) begin
                n_fail++;
                $display("FAIL fill_hold%0d got=%b/%b exp=%b/%b", c, instr_valid, fetch_ready, exp_valid(), exp_ready());
            end
            for (int j = 0; j < DN; j++) begin
                n_checks++;
                if (instr[j] !== exp_ins(j) || instr_pc[j] !== exp_pc(j)) begin
                    n_fail++;
                    $display("FAIL fill_hold_slot%0d got=%h/%h exp=%h/%h", j, instr[j], instr_pc[j], exp_ins(j), exp_pc(j));
                end
            end
        end
        // dec_accept must not reach fetch_ready combinationally
        dec_accept = 3'd4;
        #1;
        n_checks++;
        if (fetch_ready !== exp_ready()) begin
            n_fail++; $display("FAIL fill_ready_comb got=%b exp=%b", fetch_ready, exp_ready());
        end
        tick();
        fetch_valid = 1'b0;
        n_checks++;
        if (fetch_ready !== exp_ready()) begin
            n_fail++; $display("FAIL fill_restore_ready got=%b exp=%b", fetch_ready, exp_ready());
        end
        guard = 0;
        while (sb_q.size() > 0 && guard < 8) begin
            for (int j = 0; j < DN; j++) begin
                n_checks++;
                if (instr[j] !== exp_ins(j) || instr_pc[j] !== exp_pc(j)) begin
                    n_fail++;
                    $display("FAIL fill_drain_slot%0d got=%h/%h exp=%h/%h", j, instr[j], instr_pc[j], exp_ins(j), exp_pc(j));
                end
            end
            tick();
            guard++;
        end
        idle();
        n_checks++;
        if (instr_valid !== exp_valid()) begin
            n_fail++; $display("FAIL fill_drained got=%b exp=%b", instr_valid, exp_valid());
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] pc;
        pc = 64'h0000_2000;
        load_group(pc, 3);
        tick();
        for (int c = 0; c < 20; c++) begin
            pc += 64'd12;
            load_group(pc, 3);
            dec_accept = 3'd3;
            tick();
            n_checks++;
            if (instr_valid !== exp_valid() || instr_valid !== 4'b0111) begin
                n_fail++; $display("FAIL wrap_valid c%0d got=%b exp=%b", c, instr_valid, exp_valid());
            end
            for (int j = 0; j < DN; j++) begin
                n_checks++;
                if (instr[j] !== exp_ins(j) || instr_pc[j] !== exp_pc(j)) begin
                    n_fail++;
                    $display("FAIL wrap_slot%0d c%0d got=%h/%h exp=%h/%h", j, c, instr[j], instr_pc[j], exp_ins(j), exp_pc(j));
                end
            end
        end
        idle();
        dec_accept = 3'd4;
        tick();
        idle();
    endtask

    task automatic test_flush();
        load_group(64'h0000_3000, 4);
        tick();
        load_group(64'h0000_3010, 4);
        tick();
        flush       = 1'b1;
        fetch_valid = 1'b1;
        dec_accept  = 3'd2;
        tick();
        idle();
        n_checks++;
        if (instr_valid !== exp_valid() || fetch_ready !== exp_ready()) begin
            n_fail++;
            $display("FAIL flush_state got=%b/%b exp=%b/%b", instr_valid, fetch_ready, exp_valid(), exp_ready());
        end
        n_checks++;
        if (instr[0] !== NOP || instr_pc[0] !== '0) begin
            n_fail++; $display("FAIL flush_slot0 got=%h/%h exp=%h/0", instr[0], instr_pc[0], NOP);
        end
        // over-accept with a single entry
        load_group(64'h0000_4000, 1);
        tick();
        idle();
        n_checks++;
        if (instr_valid !== exp_valid()) begin
            n_fail++; $display("FAIL overacc_one got=%b exp=%b", instr_valid, exp_valid());
        end
        dec_accept = 3'd4;
        tick();
        idle();
        n_checks++;
        if (instr_valid !== exp_valid() || fetch_ready !== exp_ready()) begin
            n_fail++;
            $display("FAIL overacc_empty got=%b/%b exp=%b/%b", instr_valid, fetch_ready, exp_valid(), exp_ready());
        end
        load_group(64'h0000_4100, 4);
        tick();
        idle();
        n_checks++;
        if (instr_valid !== exp_valid()) begin
            n_fail++; $display("FAIL overacc_refill got=%b exp=%b", instr_valid, exp_valid());
        end
        for (int j = 0; j < DN; j++) begin
            n_checks++;
            if (instr[j] !== exp_ins(j) || instr_pc[j] !== exp_pc(j)) begin
                n_fail++;
                $display("FAIL overacc_slot%0d got=%h/%h exp=%h/%h", j, instr[j], instr_pc[j], exp_ins(j), exp_pc(j));
            end
        end
        dec_accept = 3'd4;
        tick();
        idle();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] pc;
        int            cnt;
        pc = 64'hFFFF_FFFF_FFFF_FFE0;
        for (int c = 0; c < 60; c++) begin
            cnt = $urandom_range(1, 4);
            load_group(pc, cnt);
            fetch_valid = ($urandom_range(0, 3) != 0);
            dec_accept  = 3'($urandom_range(0, 4));
            flush       = ($urandom_range(0, 19) == 0);
            if (fetch_valid && fetch_ready && !flush) pc += 64'(4 * cnt);
            tick();
            n_checks++;
            if (instr_valid !== exp_valid() || fetch_ready !== exp_ready()) begin
                n_fail++;
                $display("FAIL b2b_state c%0d got=%b/%b exp=%b/%b", c, instr_valid, fetch_ready, exp_valid(), exp_ready());
            end
            for (int j = 0; j < DN; j++) begin
                n_checks++;
                if (instr[j] !== exp_ins(j) || instr_pc[j] !== exp_pc(j)) begin
                    n_fail++;
                    $display("FAIL b2b_slot%0d c%0d got=%h/%h exp=%h/%h", j, c, instr[j], instr_pc[j], exp_ins(j), exp_pc(j));
                end
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        load_group(64'h0000_6000, 4);
        tick();
        idle();
        n_checks++;
        if (instr_valid !== exp_valid()) begin
            n_fail++; $display("FAIL areset_pre got=%b exp=%b", instr_valid, exp_valid());
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        sb_q.delete();
        #1;
        // still 2 time units before the next rising edge
        n_checks++;
        if (instr_valid !== exp_valid() || fetch_ready !== exp_ready()) begin
            n_fail++;
            $display("FAIL areset_now got=%b/%b exp=%b/%b", instr_valid, fetch_ready, exp_valid(), exp_ready());
        end
        n_checks++;
        if (instr[0] !== NOP || instr_pc[0] !== '0) begin
            n_fail++; $display("FAIL areset_slot0 got=%h/%h exp=%h/0", instr[0], instr_pc[0], NOP);
        end
        #1;
        rst = 1'b0;
        load_group(64'h0000_7000, 2);
        tick();
        idle();
        n_checks++;
        if (instr_valid !== exp_valid()) begin
            n_fail++; $display("FAIL areset_after got=%b exp=%b", instr_valid, exp_valid());
        end
        for (int j = 0; j < DN; j++) begin
            n_checks++;
            if (instr[j] !== exp_ins(j) || instr_pc[j] !== exp_pc(j)) begin
                n_fail++;
                $display("FAIL areset_slot%0d got=%h/%h exp=%h/%h", j, instr[j], instr_pc[j], exp_ins(j), exp_pc(j));
            end
        end
    endtask

    initial begin
        test_reset();
        test_push_basic();
        test_partial();
        test_fill();
        test_wrap();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
